freq_meas_sched: RTL and testbench

- Measurement sequencer for the equal-precision frequency meter.
- Runs the software gate window, clears and collects the gated counts, and hands them to the shared divider using a start/done handshake.
- Auto-ranges the divider result into a 6-digit value with a unit flag for the 595 dynamic display.
- Sits between the counting datapath and the divider on one side, and the display driver on the other.

---
 rtl/freq_meas_sched_if.sv | 39 +++
 rtl/freq_meas_sched.sv | 187 ++++++++++++++++++
 tb/tb_freq_meas_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_meas_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : freq_meas_sched_if
// Brief   : Signal bundle between the measurement sequencer, the counting
//           datapath, the shared divider and the display driver.
// Rev     : 1.0  initial release
// ============================================================================
interface freq_meas_sched_if;
    logic        meas_en;
    logic        gate_soft;
    logic        cnt_clr;
    logic        cnt_vld;
    logic [31:0] cnt_x;
    logic [31:0] cnt_std;
    logic        div_start;
    logic [63:0] div_num;
    logic [31:0] div_den;
    logic        div_done;
    logic [31:0] div_q;
    logic [19:0] disp_data;
    logic        disp_unit;
    logic [5:0]  disp_point;
    logic        meas_done;
    logic        err_nosig;
    logic        err_ovf;

    modport master (
        input  meas_en, cnt_vld, cnt_x, cnt_std, div_done, div_q,
        output gate_soft, cnt_clr, div_start, div_num, div_den,
               disp_data, disp_unit, disp_point, meas_done, err_nosig, err_ovf
    );

    modport slave (
        output meas_en, cnt_vld, cnt_x, cnt_std, div_done, div_q,
        input  gate_soft, cnt_clr, div_start, div_num, div_den,
               disp_data, disp_unit, disp_point, meas_done, err_nosig, err_ovf
    );
endinterface
`default_nettype wire

// File: rtl/freq_meas_sched.sv
`default_nettype none
// ============================================================================
// Module  : freq_meas_sched
// Brief   : Equal-precision frequency meter sequencer: gate timing, count
//           collection, divider handshake and display auto-ranging.
// Rev     : 1.0  initial release
// ============================================================================
module freq_meas_sched #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned PRE_CYC  = 12_500_000,
    parameter int unsigned GATE_CYC = 50_000_000,
    parameter int unsigned POST_CYC = 12_500_000,
    parameter int unsigned TMO_CYC  = 1_000_000
) (
    input  wire logic          sys_clk,
    input  wire logic          sys_rst,
    freq_meas_sched_if.master  bus
);

    localparam logic [31:0] c_RANGE_LAST = 32'd32;
    localparam logic [31:0] c_DISP_MAX   = 32'd999_999;
    localparam logic [9:0]  c_KILO       = 10'd1000;
    localparam logic [5:0]  c_DISP_POINT = 6'b001000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRE      = 3'd1,
        S_GATE     = 3'd2,
        S_POST     = 3'd3,
        S_WAIT_CNT = 3'd4,
        S_DIV_WAIT = 3'd5,
        S_RANGE    = 3'd6,
        S_UPDATE   = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_cnt;

    logic        r_gate;
    logic        r_cnt_clr;
    logic        r_div_start;
    logic [63:0] r_div_num;
    logic [31:0] r_div_den;
    logic [31:0] r_hz;
    logic [31:0] r_quo;
    logic [9:0]  r_rem;
    logic [19:0] r_disp_data;
    logic        r_disp_unit;
    logic        r_meas_done;
    logic        r_err_nosig;
    logic        r_err_ovf;

    logic        w_take_div;
    logic [10:0] w_rem_sh;
    logic        w_ge;
    logic [9:0]  w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [19:0] w_res_data;
    logic        w_res_unit;
    logic        w_res_nosig;
    logic        w_res_ovf;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_take_div = 1'b0;
        case (r_state)
            S_IDLE:     if (bus.meas_en) w_next = S_PRE;
            S_PRE:      if (r_cnt == PRE_CYC - 1) w_next = S_GATE;
            S_GATE:     if (r_cnt == GATE_CYC - 1) w_next = S_POST;
            S_POST:     if (r_cnt == POST_CYC - 1) w_next = S_WAIT_CNT;
            S_WAIT_CNT: begin
                if (bus.cnt_vld) begin
                    if (bus.cnt_std != 32'd0) begin
                        w_next     = S_DIV_WAIT;
                        w_take_div = 1'b1;
                    end else begin
                        w_next = S_UPDATE;
                    end
                end else if (r_cnt == TMO_CYC - 1) begin
                    w_next = S_UPDATE;
                end
            end
            S_DIV_WAIT: if (bus.div_done) w_next = S_RANGE;
            S_RANGE:    if (r_cnt == c_RANGE_LAST) w_next = S_UPDATE;
            S_UPDATE:   w_next = bus.meas_en ? S_PRE : S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // One restoring step of Hz / 1000; the remainder always stays below 1000.
    always_comb begin
        w_rem_sh  = {r_rem, r_quo[31]};
        w_ge      = (w_rem_sh >= {1'b0, c_KILO});
        w_rem_nxt = w_ge ? (w_rem_sh[9:0] - c_KILO) : w_rem_sh[9:0];
        w_quo_nxt = {r_quo[30:0], w_ge};
    end

    // Result presented on UPDATE entry; in RANGE the last step's quotient is w_quo_nxt.
    always_comb begin
        w_res_data  = 20'd0;
        w_res_unit  = 1'b0;
        w_res_nosig = 1'b0;
        w_res_ovf   = 1'b0;
        if (r_state == S_WAIT_CNT) begin
            w_res_nosig = 1'b1;
        end else if (r_hz <= c_DISP_MAX) begin
            w_res_data = r_hz[19:0];
        end else if (w_quo_nxt <= c_DISP_MAX) begin
            w_res_data = w_quo_nxt[19:0];
            w_res_unit = 1'b1;
        end else begin
            w_res_data = c_DISP_MAX[19:0];
            w_res_unit = 1'b1;
            w_res_ovf  = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt       <= 32'd0;
            r_gate      <= 1'b0;
            r_cnt_clr   <= 1'b0;
            r_div_start <= 1'b0;
            r_div_num   <= 64'd0;
            r_div_den   <= 32'd0;
            r_hz        <= 32'd0;
            r_quo       <= 32'd0;
            r_rem       <= 10'd0;
            r_disp_data <= 20'd0;
            r_disp_unit <= 1'b0;
            r_meas_done <= 1'b0;
            r_err_nosig <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_cnt       <= (w_next != r_state) ? 32'd0 : r_cnt + 32'd1;
            r_gate      <= (w_next == S_GATE);
            r_cnt_clr   <= (w_next == S_PRE) && (r_state != S_PRE);
            r_div_start <= w_take_div;
            r_meas_done <= (w_next == S_UPDATE);
            if (w_take_div) begin
                r_div_num <= {32'd0, bus.cnt_x} * 64'(CLK_FREQ);
                r_div_den <= bus.cnt_std;
            end
            if ((r_state == S_DIV_WAIT) && bus.div_done) begin
                r_hz <= bus.div_q;
            end
            if (r_state == S_RANGE) begin
                if (r_cnt == 32'd0) begin
                    r_quo <= r_hz;
                    r_rem <= 10'd0;
                end else begin
                    r_quo <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                end
            end
            if (w_next == S_UPDATE) begin
                r_disp_data <= w_res_data;
                r_disp_unit <= w_res_unit;
                r_err_nosig <= w_res_nosig;
                r_err_ovf   <= w_res_ovf;
            end
        end
    end

    assign bus.gate_soft  = r_gate;
    assign bus.cnt_clr    = r_cnt_clr;
    assign bus.div_start  = r_div_start;
    assign bus.div_num    = r_div_num;
    assign bus.div_den    = r_div_den;
    assign bus.disp_data  = r_disp_data;
    assign bus.disp_unit  = r_disp_unit;
    assign bus.disp_point = c_DISP_POINT;
    assign bus.meas_done  = r_meas_done;
    assign bus.err_nosig  = r_err_nosig;
    assign bus.err_ovf    = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_freq_meas_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_freq_meas_sched
// Brief   : Self-checking bench for freq_meas_sched with a behavioural divider
//           and an arithmetic display-ranging model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_freq_meas_sched;

    localparam int unsigned P_CLK  = 1000;
    localparam int unsigned P_PRE  = 4;
    localparam int unsigned P_GATE = 20;
    localparam int unsigned P_POST = 4;
    localparam int unsigned P_TMO  = 50;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;

    freq_meas_sched_if u_if ();

    freq_meas_sched #(
        .CLK_FREQ (P_CLK),
        .PRE_CYC  (P_PRE),
        .GATE_CYC (P_GATE),
        .POST_CYC (P_POST),
        .TMO_CYC  (P_TMO)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (u_if)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [19:0] data;
        logic        unit;
        logic        ovf;
        logic        nosig;
        logic        tmo;
        logic        divv;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [63:0] exp_num = 64'd0;
    logic [31:0] exp_den = 32'd0;
    bit          div_pending = 1'b0;
    bit          div_active = 1'b0;
    bit          lat_pend = 1'b0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_q = 32'd0;
    int          clr_total = 0;
    int          clr_since = 0;
    int          gate_hi = 0;
    int          rise_total = 0;
    int          fall_cyc = 0;
    int          done_cyc = 0;
    logic [19:0] prev_data = 20'd0;
    logic        prev_unit = 1'b0;
    logic        prev_ovf = 1'b0;
    logic        prev_nosig = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Display value from a frequency in Hz, straight from the ranging rules.
    function automatic exp_t model(input logic [31:0] hz);
        exp_t        e;
        logic [31:0] k;
        e.nosig = 1'b0; e.tmo = 1'b0; e.divv = 1'b1; e.ovf = 1'b0;
        if (hz <= 32'd999_999) begin
            e.data = hz[19:0]; e.unit = 1'b0;
        end else begin
            k = hz / 32'd1000;
            if (k <= 32'd999_999) begin
                e.data = k[19:0]; e.unit = 1'b1;
            end else begin
                e.data = 20'd999_999; e.unit = 1'b1; e.ovf = 1'b1;
            end
        end
        return e;
    endfunction

    // Behavioural divider, 5-cycle latency, aborted by reset.
    initial begin
        logic [63:0] t;
        logic [31:0] q;
        bit          abort;
        u_if.div_done = 1'b0;
        u_if.div_q    = 32'd0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && u_if.div_start) begin
                t = (u_if.div_den != 32'd0) ? (u_if.div_num / {32'd0, u_if.div_den}) : 64'd0;
                q = ovr_en ? ovr_q : t[31:0];
                abort = 1'b0;
                repeat (5) begin
                    @(posedge sys_clk);
                    if (sys_rst) abort = 1'b1;
                end
                if (!abort) begin
                    #1 u_if.div_done = 1'b1; u_if.div_q = q;
                    @(posedge sys_clk);
                    #1 u_if.div_done = 1'b0; u_if.div_q = $urandom;
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        cyc++;
        if (sys_rst) begin
            chk("rst_gate_soft", 64'(u_if.gate_soft), 64'd0);
            chk("rst_cnt_clr",   64'(u_if.cnt_clr),   64'd0);
            chk("rst_div_start", 64'(u_if.div_start), 64'd0);
            chk("rst_div_num",   u_if.div_num,        64'd0);
            chk("rst_div_den",   64'(u_if.div_den),   64'd0);
            chk("rst_disp_data", 64'(u_if.disp_data), 64'd0);
            chk("rst_disp_unit", 64'(u_if.disp_unit), 64'd0);
            chk("rst_disp_point",64'(u_if.disp_point),64'h08);
            chk("rst_meas_done", 64'(u_if.meas_done), 64'd0);
            chk("rst_err_nosig", 64'(u_if.err_nosig), 64'd0);
            chk("rst_err_ovf",   64'(u_if.err_ovf),   64'd0);
            prev_data = 20'd0; prev_unit = 1'b0; prev_ovf = 1'b0; prev_nosig = 1'b0;
            gate_hi = 0; clr_since = 0; div_active = 1'b0; lat_pend = 1'b0; div_pending = 1'b0;
        end else begin
            chk("disp_point", 64'(u_if.disp_point), 64'h08);
            if (u_if.cnt_clr) begin clr_total++; clr_since++; end
            if (u_if.gate_soft) begin
                if (gate_hi == 0) begin
                    chk("cnt_clr_per_meas", 64'(clr_since), 64'd1);
                    clr_since = 0;
                    rise_total++;
                end
                gate_hi++;
            end else if (gate_hi != 0) begin
                chk("gate_len", 64'(gate_hi), 64'(P_GATE));
                gate_hi = 0;
                fall_cyc = cyc;
            end
            if (u_if.div_start) begin
                chk("div_start_expected", 64'(div_pending), 64'd1);
                if (div_pending) begin
                    chk("div_num", u_if.div_num, exp_num);
                    chk("div_den", 64'(u_if.div_den), 64'(exp_den));
                end
                div_pending = 1'b0;
                div_active = 1'b1;
            end else if (div_active) begin
                chk("div_num_stable", u_if.div_num, exp_num);
                chk("div_den_stable", 64'(u_if.div_den), 64'(exp_den));
                if (u_if.div_done) begin
                    div_active = 1'b0; lat_pend = 1'b1; done_cyc = cyc;
                end
            end
            if (u_if.meas_done) begin
                if (exp_q.size() == 0) begin
                    chk("meas_done_expected", 64'd1, 64'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("disp_data", 64'(u_if.disp_data), 64'(m_e.data));
                    chk("disp_unit", 64'(u_if.disp_unit), 64'(m_e.unit));
                    chk("err_ovf",   64'(u_if.err_ovf),   64'(m_e.ovf));
                    chk("err_nosig", 64'(u_if.err_nosig), 64'(m_e.nosig));
                    if (m_e.divv) begin
                        chk("div_done_to_meas_done", lat_pend ? 64'(cyc - done_cyc) : 64'hFFFF, 64'd34);
                        lat_pend = 1'b0;
                    end
                    if (m_e.tmo) chk("timeout_latency", 64'(cyc - fall_cyc), 64'(P_POST + P_TMO));
                    prev_data = m_e.data; prev_unit = m_e.unit;
                    prev_ovf = m_e.ovf; prev_nosig = m_e.nosig;
                end
            end else begin
                chk("hold_disp_data", 64'(u_if.disp_data), 64'(prev_data));
                chk("hold_disp_unit", 64'(u_if.disp_unit), 64'(prev_unit));
                chk("hold_err_ovf",   64'(u_if.err_ovf),   64'(prev_ovf));
                chk("hold_err_nosig", 64'(u_if.err_nosig), 64'(prev_nosig));
            end
        end
    end

    task automatic pulse_vld(input logic [31:0] x, input logic [31:0] s);
        @(posedge sys_clk);
        #1 u_if.cnt_vld = 1'b1; u_if.cnt_x = x; u_if.cnt_std = s;
        @(posedge sys_clk);
        #1 u_if.cnt_vld = 1'b0; u_if.cnt_x = $urandom; u_if.cnt_std = $urandom;
    endtask

    // mode: 0 = valid counts, 1 = no cnt_vld (timeout), 2 = cnt_std of zero.
    // rst_at: 0 = none, 1 = reset during DIV_WAIT, 2 = reset during RANGE.
    task automatic do_meas(input int mode, input logic [31:0] x, input logic [31:0] s,
                           input bit ovr, input logic [31:0] qv, input int k,
                           input bit junk, input bit drop_en, input int rst_at);
        exp_t        e;
        int          n;
        int          c0;
        int          r0;
        logic [63:0] num;
        logic [63:0] qq;
        n = 0;
        while (!u_if.gate_soft && n < 400) begin @(negedge sys_clk); n++; end
        if (!u_if.gate_soft) begin chk("wait_gate_rise", 64'd0, 64'd1); return; end
        if (drop_en) u_if.meas_en = 1'b0;
        if (junk) begin
            @(posedge sys_clk);
            #1 u_if.cnt_vld = 1'b1; u_if.cnt_std = 32'd0; u_if.cnt_x = $urandom;
            @(posedge sys_clk);
            #1 u_if.cnt_vld = 1'b0;
        end
        n = 0;
        while (u_if.gate_soft && n < 100) begin @(negedge sys_clk); n++; end
        if (u_if.gate_soft) begin chk("wait_gate_fall", 64'd1, 64'd0); return; end
        ovr_en = ovr;
        ovr_q  = qv;
        e.data = 20'd0; e.unit = 1'b0; e.ovf = 1'b0; e.nosig = 1'b1;
        e.tmo = (mode == 1); e.divv = 1'b0;
        if (mode == 0) begin
            num = {32'd0, x} * 64'(P_CLK);
            exp_num = num;
            exp_den = s;
            qq = num / {32'd0, s};
            e = model(ovr ? qv : qq[31:0]);
            if (rst_at == 0) exp_q.push_back(e);
            div_pending = 1'b1;
            repeat (3 + k) @(posedge sys_clk);
            pulse_vld(x, s);
        end else if (mode == 2) begin
            exp_q.push_back(e);
            repeat (3 + k) @(posedge sys_clk);
            pulse_vld(x, 32'd0);
        end else begin
            exp_q.push_back(e);
        end
        if (rst_at != 0) begin
            n = 0;
            while (!u_if.div_start && n < 50) begin @(negedge sys_clk); n++; end
            if (rst_at == 2) begin
                n = 0;
                while (!u_if.div_done && n < 50) begin @(negedge sys_clk); n++; end
                repeat (10) @(posedge sys_clk);
            end
            @(posedge sys_clk);
            #1 sys_rst = 1'b1;
            repeat (3) @(posedge sys_clk);
            #1 sys_rst = 1'b0;
            @(negedge sys_clk);
            chk("div_num_after_rst", u_if.div_num, 64'd0);
            return;
        end
        n = 0;
        @(negedge sys_clk);
        while (!u_if.meas_done && n < 300) begin @(negedge sys_clk); n++; end
        if (!u_if.meas_done) begin chk("wait_meas_done", 64'd0, 64'd1); return; end
        if (drop_en) begin
            c0 = clr_total;
            r0 = rise_total;
            repeat (40) @(negedge sys_clk);
            chk("idle_no_cnt_clr", 64'(clr_total), 64'(c0));
            chk("idle_no_gate",    64'(rise_total), 64'(r0));
            u_if.meas_en = 1'b1;
        end
    endtask

    task automatic chk_disp(input string nm, input logic [19:0] d, input logic u,
                            input logic o, input logic ns);
        chk({nm, "_data"},  64'(u_if.disp_data), 64'(d));
        chk({nm, "_unit"},  64'(u_if.disp_unit), 64'(u));
        chk({nm, "_ovf"},   64'(u_if.err_ovf),   64'(o));
        chk({nm, "_nosig"}, 64'(u_if.err_nosig), 64'(ns));
    endtask

    initial begin
        exp_t        pin;
        logic [31:0] bnd [6];
        int          mode;
        int          cat;
        logic [31:0] x;
        logic [31:0] s;
        bit          ovr;
        bnd[0] = 32'd999_999;     bnd[1] = 32'd1_000_000;   bnd[2] = 32'd999_999_999;
        bnd[3] = 32'd1_000_000_000; bnd[4] = 32'd999_999_500; bnd[5] = 32'hFFFF_FFFF;
        u_if.meas_en = 1'b0;
        u_if.cnt_vld = 1'b0;
        u_if.cnt_x   = 32'd0;
        u_if.cnt_std = 32'd0;
        #2 sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        pin = model(32'd999_999);
        chk("model_999999_data", 64'(pin.data), 64'd999_999);
        pin = model(32'd1_000_000);
        chk("model_1M_data", 64'(pin.data), 64'd1000);
        chk("model_1M_unit", 64'(pin.unit), 64'd1);
        pin = model(32'd999_999_999);
        chk("model_999999999_ovf", 64'(pin.ovf), 64'd0);
        pin = model(32'd1_000_000_000);
        chk("model_1G_ovf", 64'(pin.ovf), 64'd1);

        repeat (2) @(posedge sys_clk);
        #1 u_if.meas_en = 1'b1;

        do_meas(0, 32'd123, 32'd20, 1'b0, 32'd0, 2, 1'b1, 1'b0, 0);
        chk_disp("basic", 20'd6150, 1'b0, 1'b0, 1'b0);
        do_meas(0, 32'd55, 32'd7, 1'b1, 32'd12_345_678, 0, 1'b0, 1'b0, 0);
        chk_disp("mhz", 20'd12345, 1'b1, 1'b0, 1'b0);
        do_meas(0, 32'd9, 32'd3, 1'b1, 32'd1_000_000_000, 10, 1'b0, 1'b0, 0);
        chk_disp("ovf", 20'd999_999, 1'b1, 1'b1, 1'b0);
        do_meas(0, 32'd9, 32'd3, 1'b1, 32'd500, 5, 1'b0, 1'b0, 0);
        chk_disp("ovf_clear", 20'd500, 1'b0, 1'b0, 1'b0);
        do_meas(1, 32'd0, 32'd0, 1'b0, 32'd0, 0, 1'b1, 1'b0, 0);
        chk_disp("timeout", 20'd0, 1'b0, 1'b0, 1'b1);
        do_meas(2, 32'd77, 32'd0, 1'b0, 32'd0, 3, 1'b0, 1'b0, 0);
        chk_disp("std_zero", 20'd0, 1'b0, 1'b0, 1'b1);
        do_meas(0, 32'd40, 32'd20, 1'b0, 32'd0, 1, 1'b0, 1'b1, 0);
        chk_disp("drop_en", 20'd2000, 1'b0, 1'b0, 1'b0);
        do_meas(0, 32'd321, 32'd20, 1'b0, 32'd0, 4, 1'b0, 1'b0, 0);
        chk_disp("after_reenable", 20'd16050, 1'b0, 1'b0, 1'b0);
        do_meas(0, 32'd77, 32'd7, 1'b0, 32'd0, 2, 1'b0, 1'b0, 1);
        do_meas(0, 32'd100, 32'd4, 1'b0, 32'd0, 0, 1'b0, 1'b0, 0);
        chk_disp("restart1", 20'd25000, 1'b0, 1'b0, 1'b0);
        do_meas(0, 32'd77, 32'd7, 1'b1, 32'd12_345_678, 2, 1'b0, 1'b0, 2);
        do_meas(0, 32'd100, 32'd8, 1'b0, 32'd0, 0, 1'b0, 1'b0, 0);
        chk_disp("restart2", 20'd12500, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            mode = ($urandom % 8 < 6) ? 0 : (($urandom % 2 == 0) ? 1 : 2);
            cat  = $urandom % 3;
            x    = (cat == 0) ? $urandom_range(0, 999) :
                   (cat == 1) ? $urandom_range(1000, 2_000_000) : $urandom;
            s    = $urandom_range(1, 40);
            ovr  = ($urandom % 4 == 0);
            do_meas(mode, x, s, ovr, bnd[$urandom % 6], $urandom_range(0, 10),
                    bit'($urandom % 2), 1'b0, 0);
        end

        repeat (5) @(negedge sys_clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        chk("watchdog", 64'd0, 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
